// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment readback path: segment ordering,
// digit patterns (active-high {g,f,e,d,c,b,a}) and the special BCD codes.
package seg_pkg;

    typedef enum logic [2:0] {
        SEG_A = 3'd0,
        SEG_B = 3'd1,
        SEG_C = 3'd2,
        SEG_D = 3'd3,
        SEG_E = 3'd4,
        SEG_F = 3'd5,
        SEG_G = 3'd6
    } seg_bit_e;

    localparam int SEG_W   = 7;
    localparam int NUM_DIG = 4;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_BAD   = 4'hE;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of an active-low segment bus into a BCD code,
// flagging any pattern that is neither a digit nor blank.
module seg7_to_bcd
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] seg_n,
    output logic [3:0]       code,
    output logic             bad
);

    logic [SEG_W-1:0] seg;

    assign seg = ~seg_n;

    always_comb begin
        code = CODE_BAD;
        bad  = 1'b0;
        case (seg)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            default: begin
                code = CODE_BAD;
                bad  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Watches the scanned digit-select / segment bus, captures each position once
// per settled dwell and publishes the four low digits once a full frame is seen.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_POS = 6,
    parameter int SETTLE  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_POS-1:0] seg_sel,
    input  logic [SEG_W-1:0]   seg_data,
    output logic [3:0]         digit3,
    output logic [3:0]         digit2,
    output logic [3:0]         digit1,
    output logic [3:0]         digit0,
    output logic               frame_valid,
    output logic               frame_err,
    output logic               sel_err
);

    localparam int                CNT_W   = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SETTLE);
    localparam logic [NUM_POS-1:0] POS_ONE = NUM_POS'(1);

    logic [NUM_POS-1:0]   sel_q_reg;
    logic [SEG_W-1:0]     data_q_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 done_reg;
    logic [NUM_POS-1:0]   seen_reg;
    logic [NUM_POS-1:0]   seen_next;
    logic                 err_reg;
    logic                 err_next;
    logic                 frame_valid_reg;
    logic                 frame_err_reg;
    logic                 sel_err_reg;
    logic [4*NUM_DIG-1:0] digit_vec;

    logic [NUM_POS-1:0] sel_act;
    logic [NUM_POS-1:0] hit;
    logic               one_hot;
    logic               multi_hot;
    logic               settled;
    logic               sample_evt;
    logic               sel_err_evt;
    logic               frame_done;
    logic [3:0]         code;
    logic               bad;

    seg7_to_bcd u_dec (
        .seg_n (data_q_reg),
        .code  (code),
        .bad   (bad)
    );

    assign sel_act     = ~sel_q_reg;
    assign one_hot     = (sel_act != '0) && ((sel_act & (sel_act - POS_ONE)) == '0);
    assign multi_hot   = (sel_act != '0) && !one_hot;
    assign settled     = (cnt_reg == CNT_MAX) && !done_reg;
    assign sample_evt  = settled && one_hot;
    assign sel_err_evt = settled && multi_hot;
    assign frame_done  = &seen_reg;
    assign hit         = sample_evt ? sel_act : '0;

    // A completing frame clears the mask and error flag; a new hit on the same edge still lands.
    assign seen_next = (frame_done ? '0 : seen_reg) | hit;
    assign err_next  = (frame_done ? 1'b0 : err_reg) | sel_err_evt | (sample_evt & bad);

    // The dwell restarts on the edge where sel_q takes a new value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q_reg       <= '1;
            data_q_reg      <= '0;
            cnt_reg         <= '0;
            done_reg        <= 1'b0;
            seen_reg        <= '0;
            err_reg         <= 1'b0;
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            sel_err_reg     <= 1'b0;
        end else begin
            sel_q_reg  <= seg_sel;
            data_q_reg <= seg_data;
            if (seg_sel != sel_q_reg) begin
                cnt_reg  <= '0;
                done_reg <= 1'b0;
            end else if (cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end else begin
                done_reg <= 1'b1;
            end
            seen_reg        <= seen_next;
            err_reg         <= err_next;
            frame_valid_reg <= frame_done & ~err_reg;
            frame_err_reg   <= frame_done & err_reg;
            sel_err_reg     <= sel_err_evt;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIG; gi++) begin : g_digit
            logic [3:0] slot_reg;
            logic [3:0] digit_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    slot_reg  <= CODE_BLANK;
                    digit_reg <= CODE_BLANK;
                end else begin
                    if (hit[gi]) begin
                        slot_reg <= code;
                    end
                    if (frame_done && !err_reg) begin
                        digit_reg <= slot_reg;
                    end
                end
            end

            assign digit_vec[4*gi +: 4] = digit_reg;
        end
    endgenerate

    assign digit0      = digit_vec[3:0];
    assign digit1      = digit_vec[7:4];
    assign digit2      = digit_vec[11:8];
    assign digit3      = digit_vec[15:12];
    assign frame_valid = frame_valid_reg;
    assign frame_err   = frame_err_reg;
    assign sel_err     = sel_err_reg;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench: each driven dwell is fed to a dwell-level reference model
// that queues expected events; a monitor pops them as the DUT pulses.
module tb_seg_scan_decoder;

    localparam int NP = 6;
    localparam int ST = 2;
    localparam int K_VALID  = 0;
    localparam int K_FERR   = 1;
    localparam int K_SELERR = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NP-1:0] seg_sel = '1;
    logic [6:0]    seg_data = '0;
    logic [3:0]    digit3, digit2, digit1, digit0;
    logic          frame_valid, frame_err, sel_err;

    seg_scan_decoder #(.NUM_POS(NP), .SETTLE(ST)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_sel     (seg_sel),
        .seg_data    (seg_data),
        .digit3      (digit3),
        .digit2      (digit2),
        .digit1      (digit1),
        .digit0      (digit0),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .sel_err     (sel_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [15:0] dig;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [6:0]  pat_tbl [10];
    logic [3:0]  m_slot [NP];
    logic [NP-1:0] m_seen;
    bit          m_err;
    logic [15:0] m_dig;

    function automatic logic [6:0] pat(input int c);
        if (c < 10) return pat_tbl[c];
        return 7'b0000000;
    endfunction

    function automatic logic [3:0] ref_decode(input logic [6:0] p);
        for (int i = 0; i < 10; i++) if (pat_tbl[i] == p) return 4'(i);
        if (p == 7'b0000000) return 4'hF;
        return 4'hE;
    endfunction

    function automatic logic [NP-1:0] pos_sel(input int p);
        logic [NP-1:0] s;
        s = '1;
        s[p] = 1'b0;
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) m_slot[i] = 4'hF;
        m_seen = '0;
        m_err  = 1'b0;
        m_dig  = 16'hFFFF;
    endtask

    // One dwell of (sel, pattern) lasting dur cycles, judged by the rules directly.
    task automatic model_dwell(input logic [NP-1:0] sel, input logic [6:0] pat_hi, input int dur);
        int   lows;
        int   idx;
        logic [3:0] c;
        exp_t e;
        lows = NP - $countones(sel);
        if (dur < ST + 1 || lows == 0) return;
        if (lows > 1) begin
            e.kind = K_SELERR;
            e.dig  = m_dig;
            exp_q.push_back(e);
            m_err = 1'b1;
            return;
        end
        idx = 0;
        for (int i = 0; i < NP; i++) if (!sel[i]) idx = i;
        c = ref_decode(pat_hi);
        if (c == 4'hE) m_err = 1'b1;
        m_slot[idx] = c;
        m_seen[idx] = 1'b1;
        if (m_seen == '1) begin
            if (m_err) begin
                e.kind = K_FERR;
            end else begin
                m_dig  = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
                e.kind = K_VALID;
            end
            e.dig = m_dig;
            exp_q.push_back(e);
            m_seen = '0;
            m_err  = 1'b0;
        end
    endtask

    task automatic drive(input logic [NP-1:0] sel, input logic [6:0] pat_hi, input int dur);
        model_dwell(sel, pat_hi, dur);
        seg_sel  = sel;
        seg_data = ~pat_hi;
        repeat (dur) @(negedge clk);
    endtask

    task automatic scan(input int c3, input int c2, input int c1, input int c0, input int dur2);
        drive(pos_sel(0), pat(c0), 4);
        drive(pos_sel(1), pat(c1), 4);
        drive(pos_sel(2), pat(c2), dur2);
        drive(pos_sel(3), pat(c3), 4);
        drive(pos_sel(4), pat(15), 4);
        drive(pos_sel(5), pat(15), 4);
        drive('1, 7'b0, 3);
    endtask

    task automatic check_digits(input string name);
        logic [15:0] got;
        got = {digit3, digit2, digit1, digit0};
        checks++;
        if (got !== m_dig) begin
            errors++;
            $display("FAIL %s digits got=%h expected=%h", name, got, m_dig);
        end
    endtask

    task automatic check_event(input int kind);
        exp_t e;
        logic [15:0] got;
        got = {digit3, digit2, digit1, digit0};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d at %0t, expected none", kind, $time);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind) begin
            errors++;
            $display("FAIL event_kind got=%0d expected=%0d at %0t", kind, e.kind, $time);
        end
        if (kind != K_SELERR) begin
            checks++;
            if (got !== e.dig) begin
                errors++;
                $display("FAIL event_digits got=%h expected=%h at %0t", got, e.dig, $time);
            end else begin
                $display("event kind=%0d digits=%h", kind, got);
            end
        end else begin
            $display("event sel_err");
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (sel_err)     check_event(K_SELERR);
            if (frame_valid) check_event(K_VALID);
            if (frame_err)   check_event(K_FERR);
        end
    end

    initial begin
        logic [NP-1:0] prev_sel;
        logic [NP-1:0] s;
        logic [6:0]    p;
        int            r;
        int            a;
        int            b;

        pat_tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
        model_reset();
        repeat (3) @(negedge clk);
        check_digits("reset");
        checks++;
        if ({frame_valid, frame_err, sel_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses got=%b expected=000", {frame_valid, frame_err, sel_err});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);

        scan(1, 2, 3, 4, 4);
        check_digits("scan_1234");

        scan(5, 6, 7, 8, 2);
        check_digits("short_dwell");
        scan(5, 6, 7, 8, 4);
        check_digits("after_short");

        drive(pos_sel(0), pat(9), 4);
        drive(pos_sel(1), 7'b1010101, 4);
        drive(pos_sel(2), pat(9), 4);
        drive(pos_sel(3), pat(9), 4);
        drive(pos_sel(4), pat(15), 4);
        drive(pos_sel(5), pat(15), 4);
        drive('1, 7'b0, 3);
        check_digits("bad_pattern_hold");
        scan(9, 0, 1, 2, 4);
        check_digits("clean_after_bad");

        drive(pos_sel(0), pat(3), 4);
        drive(pos_sel(1), pat(3), 4);
        drive(6'b110011, pat(8), 5);
        drive(pos_sel(2), pat(3), 4);
        drive(pos_sel(3), pat(3), 4);
        drive(pos_sel(4), pat(15), 4);
        drive(pos_sel(5), pat(15), 4);
        drive('1, 7'b0, 3);
        check_digits("multi_hot");
        scan(4, 4, 4, 4, 4);
        check_digits("clean_after_multi");

        drive(pos_sel(0), pat(7), 4);
        drive(pos_sel(1), pat(7), 4);
        drive(pos_sel(2), pat(7), 4);
        drive('1, 7'b0, 2);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_digits("reset_mid_frame");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        drive(pos_sel(3), pat(6), 4);
        drive(pos_sel(4), pat(15), 4);
        drive(pos_sel(5), pat(15), 4);
        drive('1, 7'b0, 3);
        check_digits("partial_after_reset");
        scan(6, 5, 4, 3, 4);
        check_digits("full_after_reset");

        drive(pos_sel(0), pat(1), 4);
        drive(pos_sel(1), pat(2), 4);
        drive(pos_sel(0), pat(8), 4);
        drive(pos_sel(2), pat(3), 4);
        drive(pos_sel(3), pat(4), 4);
        drive(pos_sel(4), pat(15), 4);
        drive(pos_sel(5), pat(15), 4);
        drive('1, 7'b0, 3);
        check_digits("repeat_pos0");

        prev_sel = '1;
        for (int n = 0; n < 400; n++) begin
            do begin
                r = int'($urandom_range(0, 99));
                if (r < 75) begin
                    s = pos_sel(int'($urandom_range(0, NP - 1)));
                end else if (r < 88) begin
                    s = '1;
                end else begin
                    a = int'($urandom_range(0, NP - 1));
                    b = (a + int'($urandom_range(1, NP - 1))) % NP;
                    s = pos_sel(a);
                    s[b] = 1'b0;
                end
            end while (s == prev_sel);
            r = int'($urandom_range(0, 99));
            if (r < 80)      p = pat(int'($urandom_range(0, 9)));
            else if (r < 90) p = 7'b0000000;
            else             p = 7'($urandom);
            drive(s, p, int'($urandom_range(1, 6)));
            prev_sel = s;
        end
        drive('1, 7'b0, 20);
        check_digits("random_end");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got=%0d expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
